seq_div: RTL and testbench

Multi-cycle iterative integer divider; the inverse-operation companion to the team's sequential multiplier.
- Serves MIPS DIV/DIVU in the mult/div unit and shares the multiplier's start/isready handshake.
- Result packs remainder (HI) above quotient (LO) so the HI/LO write path is shared with multiply.
- Radix-2 restoring division on magnitudes, followed by a sign-fix step.

---
 rtl/seq_div_pkg.sv | 11 +
 rtl/seq_div_step.sv | 22 ++
 rtl/seq_div.sv | 156 +++++++++++++++
 tb/tb_seq_div.sv | 133 +++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential divider (seq_div).
package seq_div_pkg;
  localparam int WIDTH_DEF = 32;
  // Iterations per operation at the default width; the mult/div unit sizes its
  // scheduling from this.
  localparam int DIV_ITER = WIDTH_DEF;
  // Quotient reported for a zero divisor at the default width.
  localparam logic [WIDTH_DEF-1:0] DZ_QUO = '1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;
endpackage

// File: rtl/seq_div_step.sv
// One radix-2 restoring division iteration on magnitudes: shift {rem,quo}
// left by one, trial-subtract the divisor, keep the difference if it fits.
module seq_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] sh;
  logic           ge;

  // Shifted partial remainder needs WIDTH+1 bits; the restore leaves the shift.
  always_comb begin
    sh    = {rem_i, quo_i[WIDTH-1]};
    ge    = (sh >= {1'b0, dvs_i});
    rem_o = ge ? WIDTH'(sh - {1'b0, dvs_i}) : sh[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], ge};
  end
endmodule

// File: rtl/seq_div.sv
// Multi-cycle iterative signed/unsigned divider, result {remainder, quotient}.
// Optional macro SEQ_DIV_EARLY_TERM_EN: finish in one iteration slot when the
// divisor is zero or |a| < |b|.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               start,
  input  logic               is_signed,
  output logic [2*WIDTH-1:0] s,
  output logic               isready,
  output logic               busy,
  output logic               div_zero
);
  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DZ_Q = '1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d, bz_q, bz_d, dz_q, dz_d;
  logic [2*WIDTH-1:0] s_q, s_d;

  logic               sa, sb, early;
  logic [WIDTH-1:0]   mag_a, mag_b, rem_nx, quo_nx, q_fix, r_fix;

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_nx),
    .quo_o (quo_nx)
  );

  // Operand magnitudes and signs (unsigned mode passes raw values through).
  always_comb begin
    sa    = is_signed & a[WIDTH-1];
    sb    = is_signed & b[WIDTH-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
    q_fix = qneg_q ? -quo_q : quo_q;
    r_fix = rneg_q ? -rem_q : rem_q;
  end

`ifdef SEQ_DIV_EARLY_TERM_EN
  logic early_q, early_d;

  // Trivial operands are decided at accept time and retired at the next edge.
  always_comb begin
    early_d = early_q;
    if ((state_q == IDLE || state_q == DONE) && start)
      early_d = (mag_b == '0) || (mag_a < mag_b);
  end

  // Early-termination flag register.
  always_ff @(posedge clk) begin
    if (reset) early_q <= 1'b0;
    else       early_q <= early_d;
  end

  assign early = early_q;
`else
  assign early = 1'b0;
`endif

  // Next-state and datapath updates for IDLE -> RUN -> FIX -> DONE.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    dz_d    = dz_q;
    s_d     = s_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          dvs_d   = mag_b;
          quo_d   = mag_a;
          rem_d   = '0;
          cnt_d   = '0;
          qneg_d  = sa ^ sb;
          rneg_d  = sa;
          bz_d    = (b == '0);
          dz_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (early) begin
          // |a| < |b| means quotient 0 and remainder equal to the raw dividend.
          s_d     = {a_q, bz_q ? DZ_Q : {WIDTH{1'b0}}};
          dz_d    = bz_q;
          state_d = DONE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = FIX;
        end
      end
      FIX: begin
        // A zero divisor bypasses sign fixing: the raw dividend is the remainder.
        s_d     = bz_q ? {a_q, DZ_Q} : {r_fix, q_fix};
        dz_d    = bz_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      dz_q    <= 1'b0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
      dz_q    <= dz_d;
      s_q     <= s_d;
    end
  end

  assign s        = s_q;
  assign isready  = (state_q == DONE);
  assign busy     = (state_q == RUN) || (state_q == FIX);
  assign div_zero = dz_q;
endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed cases plus randomized operands
// against a plain-arithmetic truncating-division model.
module tb_seq_div;
  logic        clk = 1'b0;
  logic        reset, start, is_signed;
  logic [31:0] a, b;
  logic [63:0] s;
  logic        isready, busy, div_zero;
  int          total = 0;
  int          bad = 0;

  seq_div #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .start(start),
    .is_signed(is_signed), .s(s), .isready(isready), .busy(busy),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {remainder, quotient} from the arithmetic definition of truncating division.
  function automatic logic [63:0] ref_div(input logic [31:0] av, input logic [31:0] bv, input logic sg);
    longint sa, sb, q, r;
    if (bv == 0) return {av, 32'hFFFF_FFFF};
    sa = sg ? longint'($signed(av)) : longint'(av);
    sb = sg ? longint'($signed(bv)) : longint'(bv);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_lat(input logic [31:0] av, input logic [31:0] bv, input logic sg);
`ifdef SEQ_DIV_EARLY_TERM_EN
    longint ma, mb;
    ma = sg ? longint'($signed(av)) : longint'(av);
    mb = sg ? longint'($signed(bv)) : longint'(bv);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (bv == 0 || ma < mb) return 1;
`endif
    return 33;
  endfunction

  // Launch one operation, scramble inputs after accept, then check the outcome.
  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic sg, input logic [63:0] ex);
    int k, bsy, lat;
    lat = exp_lat(av, bv, sg);
    @(negedge clk); a = av; b = bv; is_signed = sg; start = 1'b1;
    @(negedge clk); start = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom);
    chk({tag, "_rdy_drop"}, {63'b0, isready}, 64'd0);
    k = 0; bsy = 0;
    while (!isready && k < 100) begin
      if (busy) bsy++;
      @(negedge clk); k++;
    end
    chk({tag, "_lat"}, 64'(k), 64'(lat));
    chk({tag, "_s"}, s, ex);
    chk({tag, "_dz"}, {63'b0, div_zero}, {63'b0, bv == 0});
    if (lat == 33) chk({tag, "_busy"}, 64'(bsy), 64'd33);
  endtask

  initial begin
    logic [63:0] hold;
    logic [31:0] ra, rb;
    logic        rs;
    int          k;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s", s, 64'd0);
    chk("rst_flags", {61'b0, isready, busy, div_zero}, 64'd0);
    reset = 1'b0;

    do_op("u_100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E);
    repeat (3) @(negedge clk);
    chk("hold_s", s, 64'h00000002_0000000E);
    chk("hold_rdy", {63'b0, isready}, 64'd1);
    do_op("u_big", 32'hFFFFFFE8, 32'd311, 1'b0, 64'h00000030_00D2BA08);
    do_op("s_n100_7", 32'hFFFFFF9C, 32'd7, 1'b1, 64'hFFFFFFFE_FFFFFFF2);
    do_op("s_100_n7", 32'd100, 32'hFFFFFFF9, 1'b1, 64'h00000002_FFFFFFF2);
    do_op("s_n24_311", 32'hFFFFFFE8, 32'd311, 1'b1, 64'hFFFFFFE8_00000000);
    do_op("dz_5", 32'd5, 32'd0, 1'b0, 64'h00000005_FFFFFFFF);
    do_op("dz_neg", 32'hFFFFFFF0, 32'd0, 1'b1, 64'hFFFFFFF0_FFFFFFFF);
    do_op("ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000);
    do_op("s_3_9", 32'd3, 32'd9, 1'b0, 64'h00000003_00000000);
    do_op("u_100_7b", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E);

    // A second start 10 cycles into RUN must be ignored.
    @(negedge clk); a = 32'd1000; b = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; k = 0;
    repeat (10) begin @(negedge clk); k++; end
    a = 32'd5; b = 32'd0; start = 1'b1;
    @(negedge clk); k++; start = 1'b0;
    while (!isready && k < 100) begin @(negedge clk); k++; end
    chk("ign_lat", 64'(k), 64'd33);
    chk("ign_s", s, 64'h00000001_0000014D);
    chk("ign_dz", {63'b0, div_zero}, 64'd0);

    // Reset 20 cycles into RUN abandons the operation.
    @(negedge clk); a = 32'd77; b = 32'd5; is_signed = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midrst_s", s, 64'd0);
    chk("midrst_flags", {61'b0, isready, busy, div_zero}, 64'd0);
    do_op("post_rst", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E);

    for (int i = 0; i < 30; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = 32'hFFFFFFFF;
        3:       rb = 32'd0 - $urandom_range(1, 300);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
      do_op("rand", ra, rb, rs, ref_div(ra, rb, rs));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
